// File: rtl/bsr_piso_tx_ctrl.sv
// bsr_piso_tx_ctrl: valid/ready fed serial transmitter built on a bidirectional
// PISO shift register. Each accepted word is shifted out MSB- or LSB-first, one
// bit per tick, with a sout_valid strobe per bit and frame_last on the final bit.
// Optional: define BSR_PISO_TX_PARITY_EN to append an even-parity bit per frame.
module bsr_piso_tx_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pin,
    input  logic             in_mode,
    input  logic             tick,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StParity
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sout_q, sout_d;
    logic               sout_valid_q, sout_valid_d;
    logic               frame_last_q, frame_last_d;
    logic               busy_q, busy_d;
`ifdef BSR_PISO_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // The producer may only hand over a word while nothing is in flight.
    assign in_ready   = (state_q == StIdle);
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign frame_last = frame_last_q;
    assign busy       = busy_q;

    // Next-state logic: accept in IDLE, one bit per tick in SHIFT (and PARITY).
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        mode_d       = mode_q;
        count_d      = count_q;
        sout_d       = sout_q;
        sout_valid_d = 1'b0;
        frame_last_d = 1'b0;
        busy_d       = busy_q;
`ifdef BSR_PISO_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shift_d = pin;
                    mode_d  = in_mode;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = StShift;
`ifdef BSR_PISO_TX_PARITY_EN
                    parity_d = ^pin;
`endif
                end
            end
            StShift: begin
                if (tick) begin
                    sout_d       = mode_q ? shift_q[WIDTH-1] : shift_q[0];
                    sout_valid_d = 1'b1;
                    shift_d      = mode_q ? {shift_q[WIDTH-2:0], 1'b0}
                                          : {1'b0, shift_q[WIDTH-1:1]};
                    count_d      = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
`ifdef BSR_PISO_TX_PARITY_EN
                        state_d = StParity;
`else
                        frame_last_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = StIdle;
`endif
                    end
                end
            end
`ifdef BSR_PISO_TX_PARITY_EN
            StParity: begin
                if (tick) begin
                    sout_d       = parity_q;
                    sout_valid_d = 1'b1;
                    frame_last_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            mode_q       <= 1'b0;
            count_q      <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            frame_last_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef BSR_PISO_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            mode_q       <= mode_d;
            count_q      <= count_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            frame_last_q <= frame_last_d;
            busy_q       <= busy_d;
`ifdef BSR_PISO_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

endmodule

// File: doc/bsr_piso_tx_ctrl.md
Name: bsr_piso_tx_ctrl

Overview:
- Serial-transmit controller around a bidirectional parallel-in/serial-out shift register.
- Accepts parallel words over a valid/ready handshake and loads each one into an internal shift register.
- Shifts the word out one bit per bit-rate tick, MSB-first or LSB-first, selected per word.
- Sits between a parallel producer (register file or FIFO) and a serial line driver; handles framing, pacing and busy/ready back-pressure.

Parameters:
- WIDTH, 4: data word width in bits; must be ≥2.
- CNT_W, $clog2(WIDTH+1): width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on pin/in_mode.
- in_ready  output  1  controller can accept a word. Combinational: high only in IDLE.
- pin  input  WIDTH  parallel word to transmit.
- in_mode  input  1  1 = left shift (MSB first), 0 = right shift (LSB first). Captured with the word.
- tick  input  1  bit-rate enable; one bit is emitted per cycle with tick=1 while in SHIFT.
- sout  output  1  serial data; holds its last value between ticks.
- sout_valid  output  1  one-cycle strobe; high in the cycle after each emitted bit's edge.
- frame_last  output  1  high together with sout_valid for the final bit of a frame.
- busy  output  1  registered; high from the accept edge until the edge that emits the final bit.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - State goes to IDLE.
  - shift, count, sout, sout_valid, frame_last and busy are all cleared to 0.
  - Reset overrides every other input, including a mid-frame reset; the in-flight word is discarded with no further output.
- States: IDLE, SHIFT (and PARITY when compiled in).
- IDLE:
  - in_ready=1.
  - Accept occurs at an edge where in_valid=1.
  - On accept: shift<=pin, mode<=in_mode, count<=0, busy<=1, next state SHIFT.
  - sout_valid<=0 and frame_last<=0 every IDLE cycle.
- SHIFT:
  - in_ready=0; in_valid is ignored and pin is not sampled.
  - At an edge with tick=0: no change to shift or count; sout holds; sout_valid<=0; frame_last<=0.
  - At an edge with tick=1:
    - sout <= mode ? shift[WIDTH-1] : shift[0].
    - sout_valid<=1.
    - shift <= mode ? {shift[WIDTH-2:0],0} : {0,shift[WIDTH-1:1]}.
    - count<=count+1.
  - Last-bit edge: the tick edge with count==WIDTH-1.
    - frame_last<=1 and busy<=0.
    - Next state IDLE (or PARITY when PARITY_EN is defined).
- Latency:
  - Accept edge T0; first bit visible after the first tick edge following T0. A tick at the T0 edge itself is not consumed.
  - With tick held high, bit k is visible in the cycle after edge Tk+1, for k=0..WIDTH-1.
- Back-to-back frames:
  - The earliest next accept is the edge after the last-bit edge.
  - This gives at least one cycle with sout_valid=0 between frames.
- A tick that arrives in IDLE is ignored.
- The count never exceeds WIDTH; there is no wrap-around within a frame.

Optional Feature:
- Macro: BSR_PISO_TX_PARITY_EN.
- Defined:
  - The last data tick goes to PARITY instead of IDLE, with frame_last=0 and busy still 1.
  - PARITY waits for the next tick. At that edge: sout <= even parity (XOR of all WIDTH captured bits, latched at accept), sout_valid<=1, frame_last<=1, busy<=0, next state IDLE.
  - The frame is WIDTH+1 bits.
- Undefined: no PARITY state and no parity latch; the frame is WIDTH bits.

Test Plan:
- WIDTH=4, pin=4'b1011, in_mode=1, tick held 1 -> sout 1,0,1,1 on four consecutive sout_valid cycles; frame_last with the 4th bit; busy low after it; in_ready high the next cycle.
- pin=4'b1011, in_mode=0, tick held 1 -> sout 1,1,0,1; frame_last on the 4th bit.
- pin=4'b0110, in_mode=1, tick asserted every 3rd cycle -> exactly 4 single-cycle sout_valid strobes spaced 3 cycles apart (0,1,1,0); sout stable between strobes.
- in_valid held high with alternating words 4'hA and 4'h5, tick=1 -> each frame fully serialized; pin changes during SHIFT are ignored; one sout_valid=0 gap between frames.
- rst=1 after the 2nd bit of 4'b1111 -> next cycle sout=0, sout_valid=0, busy=0, in_ready=1; no further bits; a new word then transmits correctly.
- With BSR_PISO_TX_PARITY_EN: pin=4'b1011, mode=1 -> 1,0,1,1 then parity bit 1 with frame_last; pin=4'b0011 -> parity bit 0.
